// File: rtl/position_updater_if.sv
// Position update / position state buses between updater and position keeper.
interface PositionUpdate_IF #(
    parameter int POS_X_BITS = 16,
    parameter int POS_Y_BITS = 16
);
    logic signed [POS_X_BITS-1:0] new_x;
    logic signed [POS_Y_BITS-1:0] new_y;
    logic                         update;

    modport master (output new_x, output new_y, output update);
    modport slave  (input new_x, input new_y, input update);
endinterface

interface PositionState_IF #(
    parameter int POS_X_BITS = 16,
    parameter int POS_Y_BITS = 16
);
    logic signed [POS_X_BITS-1:0] cur_x;
    logic signed [POS_Y_BITS-1:0] cur_y;
    logic                         is_absolute;

    modport master (output cur_x, output cur_y, output is_absolute);
    modport slave  (input cur_x, input cur_y, input is_absolute);
endinterface

// File: rtl/position_updater.sv
// Move command sequencer: target/delta calc, motor handshake, position write-back.
// POSITION_SATURATE_EN: clamp relative targets instead of wrapping them.
module position_updater #(
    parameter int POS_X_BITS = 16,
    parameter int POS_Y_BITS = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic                    start,
    input  logic                    is_move,
    input  logic [POS_X_BITS-1:0]   arg_x,
    input  logic [POS_Y_BITS-1:0]   arg_y,
    output logic                    busy,
    output logic                    done,
    output logic                    move_start,
    output logic [POS_X_BITS:0]     delta_x,
    output logic [POS_Y_BITS:0]     delta_y,
    input  logic                    move_done,
    PositionUpdate_IF.master        update_intf,
    PositionState_IF.slave          state_intf
);
    localparam int XB = POS_X_BITS;
    localparam int YB = POS_Y_BITS;

    typedef enum logic [2:0] {
        IDLE, CALC, MOVE_START, MOVE_WAIT, UPDATE, DONE
    } state_t;

    state_t state_q, state_d;

    logic [XB-1:0] arg_x_q, new_x_q, tgt_x, rel_x;
    logic [YB-1:0] arg_y_q, new_y_q, tgt_y, rel_y;
    logic [XB:0]   delta_x_q, dx;
    logic [YB:0]   delta_y_q, dy;

`ifdef POSITION_SATURATE_EN
    logic [XB:0] sum_x;
    logic [YB:0] sum_y;
    logic [XB-1:0] max_x, min_x;
    logic [YB-1:0] max_y, min_y;

    // Overflow shows as disagreement between the two top bits of the wide sum
    always_comb begin
        max_x = {1'b0, {(XB-1){1'b1}}};
        min_x = {1'b1, {(XB-1){1'b0}}};
        max_y = {1'b0, {(YB-1){1'b1}}};
        min_y = {1'b1, {(YB-1){1'b0}}};
        sum_x = {state_intf.cur_x[XB-1], state_intf.cur_x} + {arg_x_q[XB-1], arg_x_q};
        sum_y = {state_intf.cur_y[YB-1], state_intf.cur_y} + {arg_y_q[YB-1], arg_y_q};
        rel_x = sum_x[XB-1:0];
        rel_y = sum_y[YB-1:0];
        if (sum_x[XB] != sum_x[XB-1]) rel_x = sum_x[XB] ? min_x : max_x;
        if (sum_y[YB] != sum_y[YB-1]) rel_y = sum_y[YB] ? min_y : max_y;
    end
`else
    always_comb begin
        rel_x = state_intf.cur_x + arg_x_q;
        rel_y = state_intf.cur_y + arg_y_q;
    end
`endif

    always_comb begin
        tgt_x = state_intf.is_absolute ? arg_x_q : rel_x;
        tgt_y = state_intf.is_absolute ? arg_y_q : rel_y;
        dx = {tgt_x[XB-1], tgt_x} - {state_intf.cur_x[XB-1], state_intf.cur_x};
        dy = {tgt_y[YB-1], tgt_y} - {state_intf.cur_y[YB-1], state_intf.cur_y};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (start) state_d = is_move ? CALC : DONE;
            CALC:       state_d = (dx == '0 && dy == '0) ? UPDATE : MOVE_START;
            MOVE_START: state_d = MOVE_WAIT;
            MOVE_WAIT:  if (move_done) state_d = UPDATE;
            UPDATE:     state_d = DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            arg_x_q   <= '0;
            arg_y_q   <= '0;
            new_x_q   <= '0;
            new_y_q   <= '0;
            delta_x_q <= '0;
            delta_y_q <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                arg_x_q <= arg_x;
                arg_y_q <= arg_y;
            end
            if (state_q == CALC) begin
                new_x_q   <= tgt_x;
                new_y_q   <= tgt_y;
                delta_x_q <= dx;
                delta_y_q <= dy;
            end
        end
    end

    assign busy               = (state_q != IDLE);
    assign done               = (state_q == DONE);
    assign move_start         = (state_q == MOVE_START);
    assign update_intf.update = (state_q == UPDATE);
    assign update_intf.new_x  = new_x_q;
    assign update_intf.new_y  = new_y_q;
    assign delta_x            = delta_x_q;
    assign delta_y            = delta_y_q;
endmodule

// File: doc/position_updater.md
# position_updater

Master side of the position update path. It accepts one move command at a time, reads the current position and coordinate mode from the position state, and computes the target and the signed per-axis delta. It hands the delta to the motor layer with a start/done handshake, then writes the target back to the position keeper with a single-cycle update pulse. It sits between the op decoder and the position keeper, as the writer of `PositionUpdate_IF` and the reader of `PositionState_IF`.

## Interface
- `POS_X_BITS`, default 16: width of a signed X coordinate.
- `POS_Y_BITS`, default 16: width of a signed Y coordinate.

- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset; 0 forces reset state immediately.
- `clk_en` in 1: state advances only on edges where `clk_en`=1.
- `start` in 1: request; accepted only in IDLE with `clk_en`=1.
- `is_move` in 1: sampled with `start`; 1 = move command, 0 = non-move (completes without update).
- `arg_x` in POS_X_BITS: signed X argument, sampled with `start`.
- `arg_y` in POS_Y_BITS: signed Y argument, sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a command completes.
- `move_start` out 1: one-cycle pulse; deltas valid.
- `delta_x` out POS_X_BITS+1: signed target_x − cur_x, held from CALC until next CALC.
- `delta_y` out POS_Y_BITS+1: signed target_y − cur_y, held likewise.
- `move_done` in 1: motor layer completion; sampled only in MOVE_WAIT.
- `update_intf` modport master, `PositionUpdate_IF`: drives `new_x`, `new_y`, `update`.
- `state_intf` modport slave, `PositionState_IF`: reads `cur_x`, `cur_y`, `is_absolute`.

## Operation
- States: IDLE, CALC, MOVE_START, MOVE_WAIT, UPDATE, DONE.
- IDLE, when `start`=1 and `clk_en`=1:
  - Latch `is_move`, `arg_x`, `arg_y`.
  - Go to CALC if `is_move`=1; otherwise go to DONE.
- CALC:
  - Sample `cur_x`, `cur_y`, `is_absolute` once.
  - Absolute: target = arg.
  - Relative: target = cur + arg, computed at width+1.
  - Register the target into `new_x`/`new_y` and the delta into `delta_x`/`delta_y`.
  - If both deltas are 0, go to UPDATE (skip the move); otherwise go to MOVE_START.
- MOVE_START: pulse `move_start`, then go to MOVE_WAIT.
- MOVE_WAIT: stay until `move_done`=1, then go to UPDATE.
- UPDATE: `update`=1 for exactly one enabled cycle, then go to DONE.
- DONE: pulse `done`, then return to IDLE.
- `start` while `busy`=1 is ignored; there is no queueing.
- `new_x`/`new_y` are stable from CALC through the end of UPDATE and hold afterwards.
- Reset values:
  - state IDLE.
  - `busy`, `done`, `move_start`, `update` all 0.
  - `new_x`, `new_y`, `delta_x`, `delta_y` all 0.
- Reset asserted mid-operation aborts the command. No `update` or `done` is issued for it.

## Timing
- Every transition requires `clk_en`=1; with `clk_en`=0, all outputs hold and pulses stretch.
- With `clk_en` held at 1, counting from the `start` accept edge:
  - Zero-delta move: `update` high in cycle 2, `done` in cycle 3.
  - Non-move: `done` in cycle 1.
  - Nonzero move: `move_start` in cycle 2. `update` is high the cycle after `move_done` is sampled, and `done` one cycle later.
- `move_done` asserted in the same cycle as `move_start` is ignored.
- Position state is read only in CALC, so later changes during MOVE_WAIT have no effect.

## Configuration
- `POSITION_SATURATE_EN` defined:
  - A relative target outside the signed coordinate range is clamped to −2^(N−1) or 2^(N−1)−1 per axis.
  - The delta is computed from the clamped target.
- Undefined: the relative target wraps modulo 2^N (truncation), and the delta is computed from the wrapped target.
- Absolute mode is unaffected by the macro.

## Test plan
- Absolute, cur=(3,−2), args=(10,5):
  - `delta`=(7,7), one `move_start`.
  - After `move_done`, `update` for 1 cycle with `new`=(10,5), then `done`.
- Relative, cur=(3,−2), args=(−4,2): `delta`=(−4,2); `new`=(−1,0).
- Relative, cur=(3,−2), args=(0,0): no `move_start`; `update` 2 cycles after accept with `new`=(3,−2).
- Relative, cur_x=32767, arg_x=1, N=16:
  - With macro: `new_x`=32767, `delta_x`=0.
  - Without macro: `new_x`=−32768, `delta_x`=−65535.
- `is_move`=0: `done` 1 cycle after accept, `update` never asserted; a second `start` during MOVE_WAIT is ignored.
- `reset`=0 during MOVE_WAIT:
  - Immediately `busy`=0 and `update`=0.
  - After release, a new absolute command (1,1) from cur=(0,0) completes normally.
